// File: rtl/adma_as_pkg.sv
// Shared types for the ADMA AXI-slave write-completion path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adma_as_pkg;

  // Field widths of the in-order completion entry. They are upper bounds.
  // Users keep only the low DMA_CHN_NUM_W / MST_ID_W bits.
  localparam int ADMA_CHN_ID_MAX_W = 8;
  localparam int ADMA_AXI_ID_MAX_W = 16;

  // AXI BRESP encodings
  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'd0,
    BRESP_EXOKAY = 2'd1,
    BRESP_SLVERR = 2'd2,
    BRESP_DECERR = 2'd3
  } bresp_e;

  // One outstanding AW transaction: owning channel and the AWID it used
  typedef struct packed {
    logic [ADMA_AXI_ID_MAX_W-1:0] awid;
    logic [ADMA_CHN_ID_MAX_W-1:0] chn_id;
  } cpl_ent_t;

endpackage

// File: rtl/adma_sync_fifo.sv
// Generic single-clock FIFO with registered pointers and an occupancy count.
// Latency: data pushed in cycle N is visible at pop_dat in cycle N+1 (show-ahead).
// Backpressure: push ignored when full, pop ignored when empty; no full-time bypass.
module adma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/adma_as_atx_cpl.sv
// Routes AXI write responses back to the issuing DMA channel in issue order.
// Latency: B to completion is combinational; counters and idle update one cycle later.
// Backpressure: m_bready follows the head channel's bwd_cpl_rdy; iss_rdy drops when OST_DEPTH are outstanding.
// Optional: define ADMA_CPL_ID_CHK_EN to store AWIDs and flag B-ID mismatches on cpl_id_err.
module adma_as_atx_cpl
  import adma_as_pkg::*;
#(
  parameter  int DMA_CHN_NUM   = 4,
  parameter  int MST_ID_W      = 5,
  parameter  int OST_DEPTH     = 8,
  localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
  localparam int OST_CNT_W     = $clog2(OST_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DMA_CHN_NUM_W-1:0] iss_chn_id,
  input  logic [MST_ID_W-1:0]      iss_awid,
  input  logic                     iss_vld,
  output logic                     iss_rdy,
  input  logic [MST_ID_W-1:0]      m_bid,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic [DMA_CHN_NUM-1:0]   bwd_cpl_vld,
  output logic [DMA_CHN_NUM*2-1:0] bwd_cpl_resp,
  input  logic [DMA_CHN_NUM-1:0]   bwd_cpl_rdy,
  output logic [DMA_CHN_NUM-1:0]   chn_idle,
  output logic                     cpl_id_err
);

`ifdef ADMA_CPL_ID_CHK_EN
  localparam int ENT_W = DMA_CHN_NUM_W + MST_ID_W;
`else
  localparam int ENT_W = DMA_CHN_NUM_W;
`endif

  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENT_W-1:0]         fifo_wdat;
  logic [ENT_W-1:0]         fifo_rdat;
  cpl_ent_t                 ent_in;
  cpl_ent_t                 ent_head;
  logic [DMA_CHN_NUM_W-1:0] head_chn;
  logic [OST_CNT_W-1:0]     ost_cnt [DMA_CHN_NUM];
  logic                     unused_bits;

  assign iss_rdy = ~fifo_full;
  assign push    = iss_vld & iss_rdy;
  assign pop     = m_bvalid & m_bready;

  // Pack the issued transaction; the AWID is only kept when ID checking is built in
  always_comb begin
    ent_in = '0;
    ent_in.chn_id[DMA_CHN_NUM_W-1:0] = iss_chn_id;
    ent_in.awid[MST_ID_W-1:0]        = iss_awid;
`ifdef ADMA_CPL_ID_CHK_EN
    fifo_wdat = {ent_in.awid[MST_ID_W-1:0], ent_in.chn_id[DMA_CHN_NUM_W-1:0]};
`else
    fifo_wdat = ent_in.chn_id[DMA_CHN_NUM_W-1:0];
`endif
  end

  // Unpack the oldest outstanding transaction
  always_comb begin
    ent_head = '0;
    ent_head.chn_id[DMA_CHN_NUM_W-1:0] = fifo_rdat[DMA_CHN_NUM_W-1:0];
`ifdef ADMA_CPL_ID_CHK_EN
    ent_head.awid[MST_ID_W-1:0] = fifo_rdat[ENT_W-1:DMA_CHN_NUM_W];
`endif
    head_chn = ent_head.chn_id[DMA_CHN_NUM_W-1:0];
  end

  adma_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OST_DEPTH)
  ) u_ord_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (fifo_wdat),
    .pop      (pop),
    .pop_dat  (fifo_rdat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Steer B to the head channel; with nothing outstanding B is held off
  always_comb begin
    bwd_cpl_vld = '0;
    m_bready    = 1'b0;
    if (!fifo_empty) begin
      bwd_cpl_vld[head_chn] = m_bvalid;
      m_bready              = bwd_cpl_rdy[head_chn];
    end
  end

  // Every channel sees the same response code; only the valid bit selects one
  assign bwd_cpl_resp = {DMA_CHN_NUM{m_bresp}};

  // Per-channel outstanding counts; a push and a pop on one channel cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
        ost_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
        case ({push && (iss_chn_id == DMA_CHN_NUM_W'(i)),
               pop  && (head_chn   == DMA_CHN_NUM_W'(i))})
          2'b10:   ost_cnt[i] <= ost_cnt[i] + OST_CNT_W'(1);
          2'b01:   ost_cnt[i] <= ost_cnt[i] - OST_CNT_W'(1);
          default: ost_cnt[i] <= ost_cnt[i];
        endcase
      end
    end
  end

  // Idle is derived from the registered counts only
  always_comb begin
    chn_idle = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      chn_idle[i] = (ost_cnt[i] == '0);
    end
  end

`ifdef ADMA_CPL_ID_CHK_EN
  // Sticky mismatch flag; the completion itself is still delivered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpl_id_err <= 1'b0;
    end else if (pop && (m_bid != ent_head.awid[MST_ID_W-1:0])) begin
      cpl_id_err <= 1'b1;
    end
  end

  assign unused_bits = ^{ent_in, ent_head};
`else
  assign cpl_id_err  = 1'b0;
  assign unused_bits = ^{ent_in, ent_head, m_bid};
`endif

endmodule

// File: tb/tb_adma_as_atx_cpl.sv
// Directed bench for adma_as_atx_cpl with an in-order scoreboard of issued channels.
// Latency: n/a.
// Backpressure: n/a.
module tb_adma_as_atx_cpl;
  import adma_as_pkg::*;

  localparam int NCH   = 4;
  localparam int IDW   = 5;
  localparam int DEPTH = 8;

`ifdef ADMA_CPL_ID_CHK_EN
  localparam logic EXP_ID_ERR = 1'b1;
`else
  localparam logic EXP_ID_ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       iss_chn_id;
  logic [IDW-1:0]   iss_awid;
  logic             iss_vld;
  logic             iss_rdy;
  logic [IDW-1:0]   m_bid;
  logic [1:0]       m_bresp;
  logic             m_bvalid;
  logic             m_bready;
  logic [NCH-1:0]   bwd_cpl_vld;
  logic [NCH*2-1:0] bwd_cpl_resp;
  logic [NCH-1:0]   bwd_cpl_rdy;
  logic [NCH-1:0]   chn_idle;
  logic             cpl_id_err;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int cnt_m[NCH];

  always #5 clk = ~clk;

  adma_as_atx_cpl #(
    .DMA_CHN_NUM (NCH),
    .MST_ID_W    (IDW),
    .OST_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_chn_id   (iss_chn_id),
    .iss_awid     (iss_awid),
    .iss_vld      (iss_vld),
    .iss_rdy      (iss_rdy),
    .m_bid        (m_bid),
    .m_bresp      (m_bresp),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .bwd_cpl_vld  (bwd_cpl_vld),
    .bwd_cpl_resp (bwd_cpl_resp),
    .bwd_cpl_rdy  (bwd_cpl_rdy),
    .chn_idle     (chn_idle),
    .cpl_id_err   (cpl_id_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] exp_idle();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (cnt_m[i] == 0);
    return v;
  endfunction

  // Entered and left at posedge+1
  task automatic do_issue(input int chn, input int awid);
    iss_vld    = 1'b1;
    iss_chn_id = chn[1:0];
    iss_awid   = awid[IDW-1:0];
    #1 chk("iss_rdy_before_push", iss_rdy, 1);
    @(posedge clk); #1;
    exp_q.push_back(chn);
    cnt_m[chn]++;
    iss_vld = 1'b0;
    chk("idle_after_issue", chn_idle, exp_idle());
  endtask

  task automatic do_cpl(input int bid, input int resp);
    int h;
    logic [NCH-1:0] oh;
    logic [1:0] r;
    h  = exp_q[0];
    oh = 4'b0001 << h;
    r  = resp[1:0];
    m_bvalid    = 1'b1;
    m_bid       = bid[IDW-1:0];
    m_bresp     = r;
    bwd_cpl_rdy = '1;
    #1;
    chk("cpl_vld_onehot", bwd_cpl_vld, oh);
    chk("cpl_resp_lanes", bwd_cpl_resp, {NCH{r}});
    chk("m_bready_head", m_bready, 1);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    cnt_m[h]--;
    m_bvalid = 1'b0;
    chk("idle_after_cpl", chn_idle, exp_idle());
  endtask

  initial begin
    rst_n       = 1'b0;
    iss_chn_id  = '0;
    iss_awid    = '0;
    iss_vld     = 1'b0;
    m_bid       = '0;
    m_bresp     = '0;
    m_bvalid    = 1'b0;
    bwd_cpl_rdy = '1;
    for (int i = 0; i < NCH; i++) cnt_m[i] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_iss_rdy", iss_rdy, 1);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_cpl_vld", bwd_cpl_vld, 0);
    chk("rst_chn_idle", chn_idle, 4'hf);
    chk("rst_id_err", cpl_id_err, 0);

    // Single transaction on channel 2
    do_issue(2, 5);
    chk("chn2_busy", chn_idle, 4'b1011);
    do_cpl(5, int'(BRESP_OKAY));
    chk("chn2_idle_again", chn_idle, 4'hf);

    // In-order routing across channels with distinct responses
    do_issue(0, 1);
    do_issue(3, 2);
    do_issue(1, 3);
    do_cpl(1, int'(BRESP_OKAY));
    do_cpl(2, int'(BRESP_SLVERR));
    do_cpl(3, int'(BRESP_DECERR));

    // B with nothing outstanding is stalled
    m_bvalid = 1'b1;
    #1;
    chk("empty_m_bready", m_bready, 0);
    chk("empty_cpl_vld", bwd_cpl_vld, 0);
    @(posedge clk); #1;
    m_bvalid = 1'b0;
    chk("empty_idle_kept", chn_idle, 4'hf);

    // Head channel not ready holds off B
    do_issue(2, 1);
    m_bvalid    = 1'b1;
    m_bid       = 5'd1;
    m_bresp     = 2'd1;
    bwd_cpl_rdy = 4'b1011;
    #1;
    chk("hold_m_bready", m_bready, 0);
    chk("hold_cpl_vld", bwd_cpl_vld, 4'b0100);
    @(posedge clk); #1;
    chk("hold_m_bready_2", m_bready, 0);
    chk("hold_idle", chn_idle, 4'b1011);
    bwd_cpl_rdy = '1;
    #1 chk("release_m_bready", m_bready, 1);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    cnt_m[2]--;
    m_bvalid = 1'b0;
    chk("release_idle", chn_idle, exp_idle());

    // Fill to OST_DEPTH, refuse a ninth, free one slot
    for (int i = 0; i < DEPTH; i++) do_issue(i % NCH, i);
    chk("full_iss_rdy", iss_rdy, 0);
    iss_vld    = 1'b1;
    iss_chn_id = 2'd3;
    @(posedge clk); #1;
    iss_vld = 1'b0;
    chk("full_push_dropped", chn_idle, exp_idle());
    do_cpl(0, 0);
    chk("one_free_iss_rdy", iss_rdy, 1);
    for (int i = 1; i < DEPTH; i++) do_cpl(i, i % 4);
    chk("drained_idle", chn_idle, 4'hf);

    // Same-cycle push and pop on channel 1
    do_issue(1, 2);
    iss_vld     = 1'b1;
    iss_chn_id  = 2'd1;
    iss_awid    = 5'd6;
    m_bvalid    = 1'b1;
    m_bid       = 5'd2;
    m_bresp     = 2'd0;
    bwd_cpl_rdy = '1;
    #1;
    chk("simul_cpl_vld", bwd_cpl_vld, 4'b0010);
    chk("simul_m_bready", m_bready, 1);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    exp_q.push_back(1);
    iss_vld  = 1'b0;
    m_bvalid = 1'b0;
    chk("simul_chn1_busy", chn_idle, 4'b1101);
    do_cpl(6, 0);
    m_bvalid = 1'b1;
    #1 chk("simul_occ_one", m_bready, 0);
    m_bvalid = 1'b0;

    // Reset with transactions in flight discards them
    do_issue(0, 1);
    do_issue(3, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
    chk("midrst_idle", chn_idle, 4'hf);
    chk("midrst_iss_rdy", iss_rdy, 1);
    m_bvalid = 1'b1;
    #1;
    chk("midrst_m_bready", m_bready, 0);
    chk("midrst_cpl_vld", bwd_cpl_vld, 0);
    m_bvalid = 1'b0;

    // B-ID mismatch: completion still routed, flag sticky until reset
    do_issue(0, 3);
    do_cpl(4, 0);
    chk("id_err_set", cpl_id_err, EXP_ID_ERR);
    @(posedge clk); #1;
    chk("id_err_held", cpl_id_err, EXP_ID_ERR);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("id_err_cleared", cpl_id_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adma_as_atx_cpl.md
ADMA_AS_ATX_CPL -- requirements
Module: adma_as_atx_cpl

Interface
REQ-001 SHALL have parameter DMA_CHN_NUM, default 4, number of DMA channels.
REQ-002 SHALL have parameter MST_ID_W, default 5, AXI ID width.
REQ-003 SHALL have parameter OST_DEPTH, default 8, max outstanding write transactions (power of 2).
REQ-004 SHALL have derived parameters DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM) and OST_CNT_W = $clog2(OST_DEPTH+1), not to be overridden.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port iss_chn_id, input, DMA_CHN_NUM_W, channel of the AW transaction being issued.
REQ-008 SHALL have port iss_awid, input, MST_ID_W, AWID of the issued transaction.
REQ-009 SHALL have ports iss_vld (input, 1) and iss_rdy (output, 1), issue handshake.
REQ-010 SHALL have ports m_bid (input, MST_ID_W), m_bresp (input, 2), m_bvalid (input, 1), m_bready (output, 1), AXI B channel.
REQ-011 SHALL have ports bwd_cpl_vld (output, DMA_CHN_NUM), bwd_cpl_resp (output, DMA_CHN_NUM*2, channel i at bits [2i+1:2i]), bwd_cpl_rdy (input, DMA_CHN_NUM), per-channel completion.
REQ-012 SHALL have port chn_idle, output, DMA_CHN_NUM, bit i high when channel i has zero outstanding.
REQ-013 SHALL have port cpl_id_err, output, 1, sticky B-ID mismatch flag.

Function
REQ-014 SHALL push {iss_chn_id, iss_awid} into an in-order FIFO of OST_DEPTH entries on iss_vld & iss_rdy.
REQ-015 SHALL drive iss_rdy = FIFO not full; no pop-to-push bypass when full.
REQ-016 SHALL route B responses strictly in issue order to the channel at the FIFO head.
REQ-017 SHALL drive bwd_cpl_vld[h] = m_bvalid & FIFO not empty for head channel h; other bits 0, combinational, zero latency.
REQ-018 SHALL drive bwd_cpl_resp for every channel = m_bresp.
REQ-019 SHALL drive m_bready = FIFO not empty & bwd_cpl_rdy[h]; with FIFO empty m_bready = 0 and B is stalled.
REQ-020 SHALL pop the FIFO on m_bvalid & m_bready.
REQ-021 SHALL keep a per-channel outstanding counter of OST_CNT_W bits: +1 on push for that channel, -1 on pop for that channel, unchanged when both occur on the same channel in one cycle.
REQ-022 SHALL handle simultaneous push and pop: FIFO occupancy unchanged, both pointers advance, wrap modulo OST_DEPTH.
REQ-023 SHALL drive chn_idle[i] = (counter i == 0), registered-counter based.

Reset
REQ-024 SHALL, on a clk edge with rst_n low, clear FIFO pointers and occupancy, all counters, and cpl_id_err.
REQ-025 SHALL present after reset: iss_rdy=1, m_bready=0, bwd_cpl_vld=0, chn_idle=all 1, cpl_id_err=0.
REQ-026 SHALL discard all in-flight entries on reset mid-operation; no completion is reported for them.

Configuration
REQ-027 SHALL, with macro ADMA_CPL_ID_CHK_EN defined, compare m_bid against the head awid on each B handshake and set cpl_id_err on mismatch, held until reset; the completion is still routed.
REQ-028 SHALL, without ADMA_CPL_ID_CHK_EN, store no awid in the FIFO and tie cpl_id_err to 0.

Structure
REQ-029 SHALL take the FIFO entry typedef (chn_id, awid) and BRESP encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) from shared package adma_as_pkg.
REQ-030 SHALL implement the FIFO as sub-module adma_sync_fifo (parameterised width/depth, full/empty outputs).

Verification
REQ-031 SHALL cover: issue chn 2 (awid 5), then B bid=5 bresp=0 -> bwd_cpl_vld=4'b0100, bresp 0, chn_idle[2] returns 1.
REQ-032 SHALL cover: issue chn 0,3,1; B x3 with resp 0,2,3 -> completions on chn 0,3,1 in order with resp 0,2,3.
REQ-033 SHALL cover: 8 issues without B -> iss_rdy=0 after 8th; one B handshake -> iss_rdy=1 next cycle.
REQ-034 SHALL cover: m_bvalid=1 with FIFO empty -> m_bready=0, bwd_cpl_vld=0; bwd_cpl_rdy[h]=0 -> m_bready=0 until asserted.
REQ-035 SHALL cover: same-cycle push and pop on chn 1 -> chn 1 counter unchanged, occupancy unchanged.
REQ-036 SHALL cover, with ADMA_CPL_ID_CHK_EN: issue awid 3, B bid 4 -> cpl_id_err=1 held; rst_n low one cycle -> 0.
